// File: rtl/ps2_keycode_rx_pkg.sv
// Shared PS/2 receiver types and command-code constants, used by the receiver,
// the command selector and the bench.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK    = 8'hF0;

  localparam logic [7:0] CMD_LIGA     = 8'h12;
  localparam logic [7:0] CMD_ZERA_A   = 8'h0F;
  localparam logic [7:0] CMD_ZERA_B   = 8'h13;
  localparam logic [7:0] CMD_ZERA_ALL = 8'h10;
  localparam logic [7:0] CMD_SOMA     = 8'h1A;
  localparam logic [7:0] CMD_SUBTRAI  = 8'h1E;
  localparam logic [7:0] CMD_INVERTE  = 8'h0C;

  // Odd parity over the eight data bits plus the parity bit
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// PS/2 line and scan-code output bundle; slave = receiver, master = keyboard/selector side.
interface ps2_keycode_rx_if;
  logic       sinal;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       keycode_valid;
  logic       break_flag;
  logic       frame_err;

  modport master (
    output sinal, ps2_data,
    input  keycode, keycode_valid, break_flag, frame_err
  );

  modport slave (
    input  sinal, ps2_data,
    output keycode, keycode_valid, break_flag, frame_err
  );
endinterface

// File: rtl/ps2_keycode_rx_sync_edge.sv
// Multi-flop synchronizer for an asynchronous PS/2 line plus falling-edge detector.
module ps2_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic fe
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  // Chains reset to the idle line level so reset release never fakes an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign fe    = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard frame receiver producing validated scan codes with a one-cycle strobe.
// Optional break-code filtering is enabled by defining PS2_BREAK_FILTER_EN.
//
// state  | meaning
// IDLE   | waiting for a start bit; timeout counter held at 0
// DATA   | shifting in D0..D7, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then accept or flag error
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  ps2_keycode_rx_if.slave   bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic sinal_lvl_unused, sinal_fe;
  logic data_lvl, data_fe_unused;

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.sinal),
    .level (sinal_lvl_unused),
    .fe    (sinal_fe)
  );

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.ps2_data),
    .level (data_lvl),
    .fe    (data_fe_unused)
  );

  ps2_state_e      state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      keycode_q, keycode_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            accept;
`ifdef PS2_BREAK_FILTER_EN
  logic            brk_q, brk_d;
  logic            pend_q, pend_d;
`endif

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_d      = to_q;
    keycode_d = keycode_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    accept    = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    brk_d     = brk_q;
    pend_d    = pend_q;
`endif

    case (state_q)
      IDLE: begin
        if (sinal_fe) begin
          if (!data_lvl) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (sinal_fe) begin
          shift_d  = {data_lvl, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (sinal_fe) begin
          par_d   = data_lvl;
          state_d = STOP;
        end
      end
      STOP: begin
        if (sinal_fe) begin
          state_d = IDLE;
          if (data_lvl && parity_ok(shift_q, par_q)) accept = 1'b1;
          else                                     err_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Timeout only runs mid-frame; a stalled frame is dropped, break-pending survives
    if (state_q == IDLE) begin
      to_d = '0;
    end else if (sinal_fe) begin
      to_d = '0;
    end else if (to_q == TO_LAST) begin
      to_d    = '0;
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      to_d = to_q + 1'b1;
    end

    if (accept) begin
`ifdef PS2_BREAK_FILTER_EN
      if (shift_q == PS2_BREAK) begin
        pend_d = 1'b1;
      end else begin
        keycode_d = shift_q;
        valid_d   = 1'b1;
        brk_d     = pend_q;
        pend_d    = 1'b0;
      end
`else
      keycode_d = shift_q;
      valid_d   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bitcnt_q  <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      to_q      <= '0;
      keycode_q <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      brk_q     <= 1'b0;
      pend_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_q      <= to_d;
      keycode_q <= keycode_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
`ifdef PS2_BREAK_FILTER_EN
      brk_q     <= brk_d;
      pend_q    <= pend_d;
`endif
    end
  end

  assign bus.keycode       = keycode_q;
  assign bus.keycode_valid = valid_q;
  assign bus.frame_err     = err_q;
`ifdef PS2_BREAK_FILTER_EN
  assign bus.break_flag    = brk_q;
`else
  assign bus.break_flag    = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: frame-level model predicts pulses, a negedge compare process checks them.
module tb_ps2_keycode_rx;
  import ps2_pkg::*;

  localparam int TO_CYC = 300;
  localparam int HALF   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ps2_keycode_rx_if bus ();

  ps2_keycode_rx #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO_CYC),
    .TO_W           (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    bit         brk;
  } ev_t;

  ev_t        exp_q[$];
  int         total = 0;
  int         bad   = 0;
  int         n_valid = 0;
  int         n_err   = 0;
  logic [7:0] model_code = 8'h00;
  bit         model_pend = 1'b0;

  // Every cycle out of reset: exclusivity, pulses against the predicted queue, held keycode
  always @(negedge clk) begin
    ev_t ev;
    if (rst_n) begin
      total++;
      if (bus.keycode_valid && bus.frame_err) begin
        bad++;
        $display("FAIL excl: valid=%0b err=%0b both high", bus.keycode_valid, bus.frame_err);
      end
      if (bus.keycode_valid || bus.frame_err) begin
        if (bus.keycode_valid) n_valid++;
        if (bus.frame_err)     n_err++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pulse: unexpected valid=%0b err=%0b code=%02h", bus.keycode_valid,
                   bus.frame_err, bus.keycode);
        end else begin
          ev = exp_q.pop_front();
          if (ev.is_err) begin
            if (!bus.frame_err) begin
              bad++;
              $display("FAIL err_pulse: got valid code=%02h, required frame_err", bus.keycode);
            end
          end else begin
            if (!bus.keycode_valid || bus.keycode !== ev.code || bus.break_flag !== ev.brk) begin
              bad++;
              $display("FAIL valid_pulse: valid=%0b code=%02h brk=%0b required code=%02h brk=%0b",
                       bus.keycode_valid, bus.keycode, bus.break_flag, ev.code, ev.brk);
            end
            model_code = ev.code;
          end
        end
      end
      total++;
      if (bus.keycode !== model_code) begin
        bad++;
        $display("FAIL keycode_held: got %02h required %02h", bus.keycode, model_code);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // bits[0]=start, [8:1]=D7..D0, [9]=parity, [10]=stop
  function automatic logic [10:0] make_frame(input logic [7:0] code, input bit flip_par,
                                             input bit stop);
    logic par;
    par = ~(^code) ^ flip_par;
    return {stop, par, code, 1'b0};
  endfunction

  task automatic predict(input logic [10:0] f);
    ev_t e;
    bit  ok;
    ok = (f[0] == 1'b0) && (f[10] == 1'b1) && (($countones(f[9:1]) % 2) == 1);
    e.is_err = !ok;
    e.code   = f[8:1];
    e.brk    = 1'b0;
    if (!ok) begin
      exp_q.push_back(e);
    end else begin
`ifdef PS2_BREAK_FILTER_EN
      if (f[8:1] == 8'hF0) begin
        model_pend = 1'b1;
      end else begin
        e.brk      = model_pend;
        model_pend = 1'b0;
        exp_q.push_back(e);
      end
`else
      exp_q.push_back(e);
`endif
    end
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 bus.sinal = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 bus.sinal = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[i]);
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [10:0] f);
    predict(f);
    send_bits(f, 11);
  endtask

  task automatic drain(input string name, input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    ev_t e;
    int  v0, e0;
    bus.sinal    = 1'b1;
    bus.ps2_data = 1'b1;
    rst_n        = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_keycode", bus.keycode, 8'h00);
    chk("rst_valid",   bus.keycode_valid, 0);
    chk("rst_brk",     bus.break_flag, 0);
    chk("rst_err",     bus.frame_err, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // 1: clean 8'h12 frame, bits 0,1,0,0,1,0,0,0 parity 1 stop 1
    chk("model_frame12", make_frame(CMD_LIGA, 0, 1), 11'b11_00010010_0);
    send_frame(make_frame(CMD_LIGA, 0, 1));
    drain("t1_drain", 100);
    chk("t1_keycode", bus.keycode, 8'h12);
    chk("t1_nvalid", n_valid, 1);
    chk("t1_nerr", n_err, 0);
    chk("t1_brk", bus.break_flag, 0);

    // 2: parity error on 8'h1A
    send_frame(make_frame(CMD_SOMA, 1, 1));
    drain("t2_drain", 100);
    chk("t2_nerr", n_err, 1);
    chk("t2_nvalid", n_valid, 1);
    chk("t2_keycode", bus.keycode, 8'h12);

    // 3: stalled frame after 4 data bits, then clean 8'h0C
    e.is_err = 1'b1; e.code = 8'h00; e.brk = 1'b0;
    exp_q.push_back(e);
    send_bits(make_frame(CMD_INVERTE, 0, 1), 5);
    drain("t3_timeout", TO_CYC + 100);
    chk("t3_nerr", n_err, 2);
    send_frame(make_frame(CMD_INVERTE, 0, 1));
    drain("t3_drain", 100);
    chk("t3_keycode", bus.keycode, 8'h0C);
    chk("t3_nvalid", n_valid, 2);

    // 4: break prefix, then F0 F0 1E
    v0 = n_valid;
    send_frame(make_frame(PS2_BREAK, 0, 1));
    send_frame(make_frame(CMD_LIGA, 0, 1));
    drain("t4_drain", 100);
    chk("t4_keycode", bus.keycode, 8'h12);
`ifdef PS2_BREAK_FILTER_EN
    chk("t4_nvalid", n_valid - v0, 1);
    chk("t4_brk", bus.break_flag, 1);
`else
    chk("t4_nvalid", n_valid - v0, 2);
    chk("t4_brk", bus.break_flag, 0);
`endif
    v0 = n_valid;
    send_frame(make_frame(PS2_BREAK, 0, 1));
    send_frame(make_frame(PS2_BREAK, 0, 1));
    send_frame(make_frame(CMD_SUBTRAI, 0, 1));
    drain("t4b_drain", 100);
    chk("t4b_keycode", bus.keycode, 8'h1E);
`ifdef PS2_BREAK_FILTER_EN
    chk("t4b_nvalid", n_valid - v0, 1);
    chk("t4b_brk", bus.break_flag, 1);
`else
    chk("t4b_nvalid", n_valid - v0, 3);
`endif

    // 5: reset in the middle of an 8'h10 frame (after D4)
    v0 = n_valid; e0 = n_err;
    send_bits(make_frame(CMD_ZERA_ALL, 0, 1), 6);
    @(posedge clk); #1;
    rst_n      = 1'b0;
    model_code = 8'h00;
    model_pend = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5_keycode", bus.keycode, 8'h00);
    chk("t5_valid", bus.keycode_valid, 0);
    chk("t5_err", bus.frame_err, 0);
    chk("t5_brk", bus.break_flag, 0);
    repeat (TO_CYC + 20) @(posedge clk);
    chk("t5_quiet", (n_valid - v0) + (n_err - e0), 0);
    send_frame(make_frame(CMD_ZERA_B, 0, 1));
    drain("t5_drain", 100);
    chk("t5_keycode13", bus.keycode, 8'h13);
    chk("t5_nvalid", n_valid - v0, 1);

    // 6: bad stop bit, then a lone glitch edge with data high
    v0 = n_valid; e0 = n_err;
    send_frame(make_frame(CMD_SUBTRAI, 0, 0));
    drain("t6a_drain", 100);
    e.is_err = 1'b1;
    exp_q.push_back(e);
    send_bits(11'h001, 1);
    drain("t6b_drain", 100);
    chk("t6_nerr", n_err - e0, 2);
    chk("t6_nvalid", n_valid - v0, 0);
    chk("t6_keycode", bus.keycode, 8'h13);

    // A start immediately after a pulse is still taken
    send_frame(make_frame(CMD_ZERA_A, 0, 1));
    send_frame(make_frame(CMD_SOMA, 0, 1));
    drain("t7_drain", 100);
    chk("t7_keycode", bus.keycode, 8'h1A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
